// File: rtl/dvp_frame_writer_pkg.sv
// Shared state encoding, word geometry and pixel-packing helper for the DVP frame writer.
package dvp_frame_writer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam int PIX_PER_WORD   = 4;
  localparam int BYTES_PER_BEAT = 8;

  function automatic logic [63:0] place_pixel(input logic [63:0] word,
                                              input logic [1:0]  slot,
                                              input logic [15:0] pix);
    logic [63:0] res;
    res = word;
    case (slot)
      2'd0:    res[15:0]  = pix;
      2'd1:    res[31:16] = pix;
      2'd2:    res[47:32] = pix;
      2'd3:    res[63:48] = pix;
      default: res        = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dvp_frame_writer_fifo.sv
// Synchronous show-ahead FIFO: dout is the head word whenever the FIFO is not empty.
module pixel_word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64
) (
  input  logic                       PCLK,
  input  logic                       Rst_p,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  always_comb begin
    push_ok_s = push && (count_q != FULL_CNT);
    pop_ok_s  = pop && (count_q != {(AW+1){1'b0}});
    wr_ptr_d  = push_ok_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d  = pop_ok_s  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge PCLK or posedge Rst_p) begin
    if (Rst_p) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the empty flag masks stale contents.
  always_ff @(posedge PCLK) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign empty = (count_q == {(AW+1){1'b0}});
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  assign dout  = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

endmodule

// File: rtl/dvp_frame_writer.sv
// Packs RGB565 pixels four per word, buffers them, and writes ping-pong frame buffers
// in fixed-length bursts, flushing partial words and bursts at each frame end.
module dvp_frame_writer
  import dvp_frame_writer_pkg::*;
#(
  parameter logic [31:0] BASE0      = 32'h0000_0000,
  parameter logic [31:0] BASE1      = 32'h0040_0000,
  parameter int          BURST_LEN  = 16,
  parameter int          FIFO_DEPTH = 64
) (
  input  logic        PCLK,
  input  logic        Rst_p,
  input  logic        in_valid,
  input  logic [15:0] in_pixel,
  input  logic        in_vs,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_addr,
  output logic [6:0]  cmd_len,
  output logic        wdata_valid,
  input  logic        wdata_ready,
  output logic [63:0] wdata,
  output logic        wdata_last,
  output logic        frame_done,
  output logic        frame_buf_sel,
  output logic        overflow
);
  localparam int            CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BURST_CNT  = CW'(BURST_LEN);
  localparam logic [6:0]    BURST_LEN7 = 7'(BURST_LEN);
  localparam logic [1:0]    LAST_SLOT  = 2'(PIX_PER_WORD - 1);

  state_e        state_q, state_d;
  logic [1:0]    slot_q, slot_d;
  logic [63:0]   word_q, word_d, cur_word_s;
  logic          vs_q, flush_q, flush_d, has_word_q, has_word_d;
  logic          overflow_q, overflow_d, frame_done_q, frame_done_d;
  logic          buf_sel_q, buf_sel_d;
  logic [6:0]    len_q, len_d, beat_q, beat_d;
  logic [31:0]   addr_q, addr_d;
  logic          vs_rise_s, accept_s, push_s, pop_s, flush_set_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [63:0]   fifo_head_s;

  pixel_word_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .PCLK  (PCLK),
    .Rst_p (Rst_p),
    .push  (push_s),
    .din   (cur_word_s),
    .pop   (pop_s),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Packer: a frame-end edge pushes whatever partial word exists, zero-padded.
  always_comb begin
    vs_rise_s   = in_vs && !vs_q;
    accept_s    = in_valid && !flush_q;
    cur_word_s  = accept_s ? place_pixel(word_q, slot_q, in_pixel) : word_q;
    slot_d      = slot_q;
    word_d      = word_q;
    push_s      = 1'b0;
    flush_set_s = 1'b0;
    if (vs_rise_s && !flush_q) begin
      flush_set_s = 1'b1;
      slot_d      = 2'd0;
      word_d      = 64'h0;
      push_s      = accept_s || (slot_q != 2'd0);
    end else if (accept_s && (slot_q == LAST_SLOT)) begin
      slot_d = 2'd0;
      word_d = 64'h0;
      push_s = 1'b1;
    end else if (accept_s) begin
      slot_d = slot_q + 2'd1;
      word_d = cur_word_s;
    end else begin
      slot_d = slot_q;
    end
    overflow_d = overflow_q || (in_valid && flush_q) || (push_s && fifo_full_s);
  end

  // Burst sequencer; a frame with no words completes silently.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    buf_sel_d    = buf_sel_q;
    frame_done_d = 1'b0;
    flush_d      = flush_q || flush_set_s;
    has_word_d   = has_word_q || push_s;
    pop_s        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_count_s >= BURST_CNT) begin
          len_d   = BURST_LEN7;
          beat_d  = 7'd0;
          state_d = S_CMD;
        end else if (flush_q && (fifo_count_s != {CW{1'b0}})) begin
          len_d   = 7'(fifo_count_s);
          beat_d  = 7'd0;
          state_d = S_CMD;
        end else if (flush_q) begin
          flush_d    = 1'b0;
          has_word_d = 1'b0;
          if (has_word_q) begin
            frame_done_d = 1'b1;
            buf_sel_d    = ~buf_sel_q;
            addr_d       = buf_sel_q ? BASE0 : BASE1;
          end else begin
            frame_done_d = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMD: begin
        if (cmd_ready) begin
          state_d = S_DATA;
        end else begin
          state_d = S_CMD;
        end
      end
      S_DATA: begin
        pop_s = !fifo_empty_s && wdata_ready;
        if (pop_s) begin
          beat_d = beat_q + 7'd1;
          if (beat_q == (len_q - 7'd1)) begin
            addr_d  = addr_q + (32'(len_q) * 32'(BYTES_PER_BEAT));
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge Rst_p) begin
    if (Rst_p) begin
      state_q      <= S_IDLE;
      slot_q       <= 2'd0;
      word_q       <= 64'h0;
      vs_q         <= 1'b0;
      flush_q      <= 1'b0;
      has_word_q   <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      buf_sel_q    <= 1'b0;
      len_q        <= 7'd0;
      beat_q       <= 7'd0;
      addr_q       <= BASE0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      word_q       <= word_d;
      vs_q         <= in_vs;
      flush_q      <= flush_d;
      has_word_q   <= has_word_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
      buf_sel_q    <= buf_sel_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
    end
  end

  assign cmd_valid     = (state_q == S_CMD);
  assign cmd_addr      = addr_q;
  assign cmd_len       = len_q;
  assign wdata_valid   = (state_q == S_DATA) && !fifo_empty_s;
  assign wdata         = fifo_head_s;
  assign wdata_last    = wdata_valid && (beat_q == (len_q - 7'd1));
  assign frame_done    = frame_done_q;
  assign frame_buf_sel = buf_sel_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_dvp_frame_writer.sv
// Directed bench for dvp_frame_writer: frame vectors from a table plus overflow and reset sequences.
`timescale 1ns/1ps
module tb_dvp_frame_writer;

  logic        PCLK = 1'b0, Rst_p = 1'b1;
  logic        in_valid = 1'b0, in_vs = 1'b0, cmd_ready = 1'b0, wdata_ready = 1'b0;
  logic [15:0] in_pixel = 16'h0;
  logic        cmd_valid, wdata_valid, wdata_last, frame_done, frame_buf_sel, overflow;
  logic [31:0] cmd_addr;
  logic [6:0]  cmd_len;
  logic [63:0] wdata;

  dvp_frame_writer dut (
    .PCLK(PCLK), .Rst_p(Rst_p), .in_valid(in_valid), .in_pixel(in_pixel), .in_vs(in_vs),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wdata_last(wdata_last),
    .frame_done(frame_done), .frame_buf_sel(frame_buf_sel), .overflow(overflow)
  );

  always #5 PCLK = ~PCLK;

  int   checks = 0, errors = 0;
  logic rand_rdy = 1'b0, mon_en = 1'b0;

  logic [31:0] addr_log[$];
  logic [6:0]  len_log[$];
  logic [63:0] beat_log[$];
  int          done_cnt, last_cnt, proto_err, beat_idx;
  logic [6:0]  cur_len, prev_len;
  logic [31:0] prev_addr;
  logic        prev_pend;

  // Bus monitor: logs handshakes and flags command instability or misplaced wdata_last.
  always @(negedge PCLK) begin
    if (!mon_en) begin
      addr_log.delete(); len_log.delete(); beat_log.delete();
      done_cnt = 0; last_cnt = 0; proto_err = 0; beat_idx = 0;
      cur_len = 7'd0; prev_pend = 1'b0; prev_addr = 32'h0; prev_len = 7'd0;
    end else begin
      if (prev_pend && (!cmd_valid || cmd_addr !== prev_addr || cmd_len !== prev_len))
        proto_err++;
      if (cmd_valid && cmd_ready) begin
        addr_log.push_back(cmd_addr); len_log.push_back(cmd_len);
        cur_len = cmd_len; beat_idx = 0;
      end
      if (wdata_valid && wdata_ready) begin
        beat_log.push_back(wdata);
        if (wdata_last !== (beat_idx == int'(cur_len) - 1)) proto_err++;
        if (wdata_last) last_cnt++;
        beat_idx++;
      end
      if (frame_done) done_cnt++;
      prev_pend = cmd_valid && !cmd_ready;
      prev_addr = cmd_addr;
      prev_len  = cmd_len;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK); #1;
    if (rand_rdy) wdata_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    Rst_p = 1'b1; tick(); tick(); Rst_p = 1'b0; tick();
  endtask

  task automatic restart_mon();
    mon_en = 1'b0; tick(); mon_en = 1'b1;
  endtask

  task automatic send_frame(input int npix);
    for (int i = 0; i < npix; i++) begin
      in_valid = 1'b1; in_pixel = 16'(i); tick();
    end
    in_valid = 1'b0; tick(); tick();
    in_vs = 1'b1; tick(); in_vs = 1'b0;
    repeat (150) tick();
  endtask

  function automatic logic [63:0] exp_word(input int k, input int npix);
    logic [63:0] w;
    w = 64'h0;
    for (int j = 0; j < 4; j++) if (4 * k + j < npix) w[16*j +: 16] = 16'(4 * k + j);
    return w;
  endfunction

  function automatic int order_errs(input int npix);
    int bad;
    bad = 0;
    for (int k = 0; k < beat_log.size(); k++) if (beat_log[k] !== exp_word(k, npix)) bad++;
    return bad;
  endfunction

  typedef struct {
    bit          do_rst;
    int          npix;
    bit          rnd;
    int          nburst;
    logic [31:0] a0;
    logic [6:0]  l0;
    logic [31:0] a1;
    logic [6:0]  l1;
    logic [63:0] first;
    logic [63:0] last;
    int          ndone;
    bit          sel;
  } vec_t;

  initial begin
    vec_t tbl[6];
    string p;
    tbl[0] = '{1'b1, 64, 1'b0, 1, 32'h0, 7'd16, 32'h0, 7'd0, 64'h0003_0002_0001_0000, 64'h003F_003E_003D_003C, 1, 1'b1};
    tbl[1] = '{1'b1, 70, 1'b0, 2, 32'h0, 7'd16, 32'h80, 7'd2, 64'h0003_0002_0001_0000, 64'h0000_0000_0045_0044, 1, 1'b1};
    tbl[2] = '{1'b0, 4, 1'b0, 1, 32'h0040_0000, 7'd1, 32'h0, 7'd0, 64'h0003_0002_0001_0000, 64'h0003_0002_0001_0000, 1, 1'b0};
    tbl[3] = '{1'b1, 64, 1'b1, 1, 32'h0, 7'd16, 32'h0, 7'd0, 64'h0003_0002_0001_0000, 64'h003F_003E_003D_003C, 1, 1'b1};
    tbl[4] = '{1'b0, 0, 1'b0, 0, 32'h0, 7'd0, 32'h0, 7'd0, 64'h0, 64'h0, 0, 1'b1};
    tbl[5] = '{1'b0, 5, 1'b0, 1, 32'h0040_0000, 7'd2, 32'h0, 7'd0, 64'h0003_0002_0001_0000, 64'h0000_0000_0000_0004, 1, 1'b0};

    tick();
    check("rst_cmd_valid", 64'(cmd_valid), 64'h0);
    check("rst_wdata_valid", 64'(wdata_valid), 64'h0);
    check("rst_wdata_last", 64'(wdata_last), 64'h0);
    check("rst_frame_done", 64'(frame_done), 64'h0);
    check("rst_overflow", 64'(overflow), 64'h0);
    check("rst_cmd_addr", 64'(cmd_addr), 64'h0);
    check("rst_cmd_len", 64'(cmd_len), 64'h0);
    check("rst_wdata", wdata, 64'h0);
    check("rst_buf_sel", 64'(frame_buf_sel), 64'h0);
    Rst_p = 1'b0; tick();

    for (int i = 0; i < 6; i++) begin
      p = $sformatf("v%0d_", i);
      if (tbl[i].do_rst) do_reset();
      cmd_ready = 1'b1; wdata_ready = 1'b1; rand_rdy = tbl[i].rnd;
      restart_mon();
      send_frame(tbl[i].npix);
      rand_rdy = 1'b0; wdata_ready = 1'b1;
      check({p, "bursts"}, 64'(addr_log.size()), 64'(tbl[i].nburst));
      if (addr_log.size() > 0 && tbl[i].nburst > 0) begin
        check({p, "addr0"}, 64'(addr_log[0]), 64'(tbl[i].a0));
        check({p, "len0"}, 64'(len_log[0]), 64'(tbl[i].l0));
      end
      if (addr_log.size() > 1 && tbl[i].nburst > 1) begin
        check({p, "addr1"}, 64'(addr_log[1]), 64'(tbl[i].a1));
        check({p, "len1"}, 64'(len_log[1]), 64'(tbl[i].l1));
      end
      check({p, "beats"}, 64'(beat_log.size()), 64'((tbl[i].npix + 3) / 4));
      if (beat_log.size() > 0) begin
        check({p, "first_beat"}, beat_log[0], tbl[i].first);
        check({p, "last_beat"}, beat_log[beat_log.size() - 1], tbl[i].last);
      end
      check({p, "order_errs"}, 64'(order_errs(tbl[i].npix)), 64'h0);
      check({p, "last_cnt"}, 64'(last_cnt), 64'(tbl[i].nburst));
      check({p, "frame_done"}, 64'(done_cnt), 64'(tbl[i].ndone));
      check({p, "buf_sel"}, 64'(frame_buf_sel), 64'(tbl[i].sel));
      check({p, "protocol"}, 64'(proto_err), 64'h0);
    end

    // Overflow: commands stalled while 1024 pixels stream in.
    do_reset();
    cmd_ready = 1'b0; wdata_ready = 1'b1;
    restart_mon();
    for (int i = 0; i < 1024; i++) begin
      in_valid = 1'b1; in_pixel = 16'(i); tick();
      if (i == 255) begin
        check("ovf_at_64_words", 64'(overflow), 64'h0);
        check("ovf_cmd_waiting", 64'(cmd_valid), 64'h1);
      end
      if (i == 259) check("ovf_after_drop", 64'(overflow), 64'h1);
    end
    in_valid = 1'b0;
    check("ovf_no_cmd_accepted", 64'(addr_log.size()), 64'h0);
    cmd_ready = 1'b1;
    tick(); tick(); in_vs = 1'b1; tick(); in_vs = 1'b0;
    repeat (150) tick();
    check("ovf_bursts", 64'(addr_log.size()), 64'd4);
    if (addr_log.size() == 4) check("ovf_addr3", 64'(addr_log[3]), 64'h180);
    check("ovf_beats", 64'(beat_log.size()), 64'd64);
    check("ovf_order_errs", 64'(order_errs(256)), 64'h0);
    if (beat_log.size() > 0) check("ovf_last_beat", beat_log[beat_log.size() - 1], 64'h00FF_00FE_00FD_00FC);
    check("ovf_sticky", 64'(overflow), 64'h1);
    check("ovf_frame_done", 64'(done_cnt), 64'h1);
    check("ovf_protocol", 64'(proto_err), 64'h0);

    // Reset during beat 5 of a burst into buffer 1.
    wdata_ready = 1'b0;
    restart_mon();
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_pixel = 16'(i); tick();
    end
    in_valid = 1'b0;
    for (int t = 0; t < 50 && !wdata_valid; t++) tick();
    check("mid_wdata_valid", 64'(wdata_valid), 64'h1);
    check("mid_addr_buf1", 64'(cmd_addr), 64'h0040_0000);
    wdata_ready = 1'b1; repeat (5) tick(); wdata_ready = 1'b0;
    check("mid_beats_taken", 64'(beat_log.size()), 64'd5);
    @(negedge PCLK); Rst_p = 1'b1; #1;
    check("mid_rst_wdata_valid", 64'(wdata_valid), 64'h0);
    check("mid_rst_wdata_last", 64'(wdata_last), 64'h0);
    check("mid_rst_cmd_addr", 64'(cmd_addr), 64'h0);
    check("mid_rst_cmd_len", 64'(cmd_len), 64'h0);
    check("mid_rst_wdata", wdata, 64'h0);
    check("mid_rst_buf_sel", 64'(frame_buf_sel), 64'h0);
    tick(); Rst_p = 1'b0; tick();
    wdata_ready = 1'b1;
    restart_mon();
    send_frame(4);
    check("post_rst_bursts", 64'(addr_log.size()), 64'h1);
    if (addr_log.size() > 0) check("post_rst_addr", 64'(addr_log[0]), 64'h0);
    if (beat_log.size() > 0) check("post_rst_beat", beat_log[0], 64'h0003_0002_0001_0000);
    check("post_rst_buf_sel", 64'(frame_buf_sel), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
